mux_n1_rr_valid: RTL and testbench
==================================

Name: mux_n1_rr_valid

Overview:
Parametrised N:1 multiplexer with per-channel valid/ready handshakes and a registered output stage. It succeeds the fixed 4:1 4-bit valid mux. Two modes are supported: external select, which matches the legacy behaviour, and round-robin arbitration among valid channels. Output backpressure is honoured and throughput is one transfer per cycle. It sits between multiple producer lanes and a single downstream consumer in the mux-with-valid datapath.

Parameters:
WIDTH, 4, data bits per channel (1..32)
CHANNELS, 4, number of input channels (2..16, need not be a power of two)
SEL_W, $clog2(CHANNELS), select/index width (derived; not overridden)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
mode  input  1  0 = external select, 1 = round-robin
select  input  SEL_W  channel index, used in mode 0 only
in_valid  input  CHANNELS  per-channel valid
in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_ready  output  CHANNELS  per-channel ready (combinational)
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered data
out_sel  output  SEL_W  index of the channel that supplied out_data
out_ready  input  1  downstream accepts the word

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release at clk):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=CHANNELS-1, so channel 0 has first priority.
  - Asserting reset mid-stall discards the held word immediately.
- Load enable: load_en = !out_valid | out_ready.
- Mode 0 (external select):
  - If select < CHANNELS: in_ready[select]=load_en; all other in_ready bits are 0.
  - If select >= CHANNELS: all in_ready bits are 0 and no transfer occurs.
- Mode 1 (round-robin):
  - grant = first k with in_valid[k]=1, searching ptr+1, ptr+2, ... and wrapping modulo CHANNELS.
  - in_ready[grant]=load_en; all other bits are 0. If no channel is valid, all bits are 0.
  - On a transfer, ptr <= grant. Otherwise ptr holds.
- Transfer on channel k: in_valid[k] & in_ready[k]. At the next edge: out_valid<=1, out_data<=in_data[k], out_sel<=k. Latency is 1 cycle.
- If load_en=1 and no transfer occurs, out_valid<=0. out_data and out_sel hold their last values.
- Stall (out_valid=1, out_ready=0):
  - out_valid, out_data and out_sel are held stable.
  - All in_ready bits are 0.
- Simultaneous drain and load (out_valid=1, out_ready=1, new transfer): the new word replaces the old one in the same edge, with no bubble.
- Mode change:
  - Sampled every cycle; no state is kept beyond ptr.
  - On a 1->0 or 0->1 edge of mode (registered previous value), ptr resets to CHANNELS-1 at that clock edge. A transfer in that same cycle still occurs, using the current mode's grant.
- in_ready never depends on in_valid of the same channel in mode 0. In mode 1 it depends on in_valid only through grant. There is no combinational path from in_data to any output.
- No data word is duplicated or dropped, except by reset.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000. Release reset; the first mode-1 transfer comes from channel 0.
2. Mode 0 pass-through, defaults: select=2, in_data lane2=4'hA, in_valid=0100, out_ready=1 -> in_ready=0100. Next cycle out_valid=1, out_data=4'hA, out_sel=2. Then drop in_valid -> out_valid=0 the following cycle.
3. Backpressure: hold out_ready=0 for 4 cycles while out_valid=1 and out_data=4'h5 -> out_data stays 4'h5 and in_ready=0000 throughout. Raise out_ready with a new word 4'h6 pending -> 4'h6 appears on the next cycle with no bubble.
4. Round-robin fairness: mode=1, in_valid=1111 continuously, out_ready=1 -> out_sel sequence is 0,1,2,3,0,1. With in_valid=1010 -> the sequence is 1,3,1,3.
5. Out-of-range select and odd channel count: CHANNELS=3, mode=0, select=3 -> in_ready=000 and out_valid=0. In mode 1 with in_valid=111 -> out_sel is 0,1,2,0 (wrap at 2).
6. Mode switch and reset mid-stall: in mode 1 after grants 0,1, switch to mode 0 then back to mode 1 -> the next RR grant is channel 0. With out_valid=1 and out_ready=0, pulse reset low for half a cycle -> out_valid=0 immediately and the held word is lost.

Source files
------------

// File: rtl/mux_n1_rr_valid_if.sv
// mux_n1_rr_valid_if: producer-lane and consumer handshake bundle for the N:1 valid mux.
interface mux_n1_rr_valid_if #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);
  logic                      mode;
  logic [SEL_W-1:0]          select;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;
  modport slave (
    input  mode, select, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
  modport master (
    output mode, select, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_n1_rr_valid.sv
// mux_n1_rr_valid: N:1 valid/ready mux with external-select or round-robin grant and a registered output.
module mux_n1_rr_valid #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input logic clk,
  input logic reset,
  mux_n1_rr_valid_if.slave bus
);
  logic [SEL_W-1:0]    ptr_q, ptr_d, out_sel_q, out_sel_d, grant, chosen;
  logic [WIDTH-1:0]    out_data_q, out_data_d, pick;
  logic                out_valid_q, out_valid_d, mode_q, found, sel_ok, load_en, xfer;
  logic [CHANNELS-1:0] ready;
  function automatic logic [SEL_W-1:0] wrap(input int v);
    return SEL_W'(v % CHANNELS);
  endfunction
  // Walk from the farthest candidate back to ptr+1 so the nearest valid lane wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = CHANNELS; i >= 1; i--)
      if (bus.in_valid[wrap(int'(ptr_q) + i)]) begin
        grant = wrap(int'(ptr_q) + i);
        found = 1'b1;
      end
  end
  always_comb begin
    pick = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (SEL_W'(k) == chosen) pick = bus.in_data[k*WIDTH +: WIDTH];
  end
  // Ready is held low while in reset so no lane sees a phantom accept.
  always_comb begin
    sel_ok      = int'(bus.select) < CHANNELS;
    chosen      = bus.mode ? grant : bus.select;
    load_en     = !out_valid_q | bus.out_ready;
    ready       = (reset && load_en && (bus.mode ? found : sel_ok)) ? CHANNELS'(1) << chosen : '0;
    xfer        = |(ready & bus.in_valid);
    out_valid_d = load_en ? xfer : out_valid_q;
    out_data_d  = xfer ? pick : out_data_q;
    out_sel_d   = xfer ? chosen : out_sel_q;
    ptr_d       = (bus.mode != mode_q) ? SEL_W'(CHANNELS - 1) : (bus.mode && xfer) ? grant : ptr_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
      mode_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
      mode_q      <= bus.mode;
    end
  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_n1_rr_valid.sv
// tb_mux_n1_rr_valid: directed bench for 4- and 3-channel muxes with an expected-word queue per instance.
module tb_mux_n1_rr_valid;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  logic [5:0] q4[$];
  logic [5:0] q3[$];
  always #5 clk = ~clk;
  mux_n1_rr_valid_if #(.WIDTH(4), .CHANNELS(4)) b4();
  mux_n1_rr_valid_if #(.WIDTH(4), .CHANNELS(3)) b3();
  mux_n1_rr_valid #(.WIDTH(4), .CHANNELS(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
  mux_n1_rr_valid #(.WIDTH(4), .CHANNELS(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic out_is(input string tag, input bit three);
    logic [6:0] obs;
    logic [5:0] e;
    logic       nonempty;
    obs = three ? {b3.out_valid, b3.out_sel, b3.out_data} : {b4.out_valid, b4.out_sel, b4.out_data};
    nonempty = three ? (q3.size() != 0) : (q4.size() != 0);
    chk({tag, "_sb"}, 32'(nonempty), 1);
    if (nonempty) begin
      e = three ? q3[0] : q4[0];
      chk(tag, 32'(obs), 32'({1'b1, e}));
      if (three && b3.out_ready) void'(q3.pop_front());
      if (!three && b4.out_ready) void'(q4.pop_front());
    end
  endtask
  initial begin
    reset = 1'b0;
    b4.mode = 1'b1; b4.select = 2'd0; b4.in_valid = 4'hF; b4.in_data = 16'h4321; b4.out_ready = 1'b1;
    b3.mode = 1'b0; b3.select = 2'd3; b3.in_valid = 3'b111; b3.in_data = 12'h321; b3.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(b4.out_valid), 0);
    chk("rst_data", 32'(b4.out_data), 0);
    chk("rst_sel", 32'(b4.out_sel), 0);
    chk("rst_ready", 32'(b4.in_ready), 0);
    chk("rst_ready3", 32'(b3.in_ready), 0);
    reset = 1'b1;
    #1;
    chk("first_ready", 32'(b4.in_ready), 32'b0001);
    q4.push_back({2'd0, 4'h1});
    tick();
    out_is("first_rr", 0);
    b4.mode = 1'b0; b4.select = 2'd2; b4.in_valid = 4'b0100; b4.in_data = 16'h4A21;
    #1;
    chk("m0_ready", 32'(b4.in_ready), 32'b0100);
    q4.push_back({2'd2, 4'hA});
    tick();
    out_is("m0_pass", 0);
    b4.in_valid = 4'b0000;
    tick();
    chk("m0_idle_valid", 32'(b4.out_valid), 0);
    chk("m0_hold_data", 32'(b4.out_data), 32'hA);
    b4.select = 2'd1; b4.in_valid = 4'b0010; b4.in_data = 16'h4A51;
    q4.push_back({2'd1, 4'h5});
    tick();
    b4.out_ready = 1'b0; b4.in_data = 16'h4A61;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_ready", 32'(b4.in_ready), 0);
      out_is("stall_hold", 0);
      tick();
    end
    b4.out_ready = 1'b1;
    #1;
    chk("bp_ready", 32'(b4.in_ready), 32'b0010);
    out_is("bp_last", 0);
    q4.push_back({2'd1, 4'h6});
    tick();
    out_is("bp_nobubble", 0);
    b4.in_valid = 4'b0000;
    tick();
    chk("bp_idle", 32'(b4.out_valid), 0);
    b4.mode = 1'b1; b4.in_data = 16'h4321;
    tick();
    b4.in_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      q4.push_back({2'(k % 4), 4'(k % 4 + 1)});
      tick();
      out_is("rr_all", 0);
    end
    b4.mode = 1'b0; b4.in_valid = 4'b0000; b4.select = 2'd0;
    tick();
    chk("rr_gap_valid", 32'(b4.out_valid), 0);
    b4.mode = 1'b1;
    tick();
    b4.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      q4.push_back(k % 2 == 0 ? {2'd1, 4'h2} : {2'd3, 4'h4});
      tick();
      out_is("rr_sparse", 0);
    end
    b4.mode = 1'b0; b4.in_valid = 4'b0000;
    tick();
    b4.mode = 1'b1;
    tick();
    b4.in_valid = 4'hF;
    for (int k = 0; k < 2; k++) begin
      q4.push_back({2'(k), 4'(k + 1)});
      tick();
      out_is("sw_pre", 0);
    end
    b4.mode = 1'b0; b4.in_valid = 4'b0000;
    tick();
    chk("sw_m0_valid", 32'(b4.out_valid), 0);
    b4.mode = 1'b1; b4.in_valid = 4'hF;
    q4.push_back({2'd0, 4'h1});
    tick();
    b4.out_ready = 1'b0; b4.in_valid = 4'b0000;
    out_is("sw_grant", 0);
    tick();
    out_is("sw_stall", 0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(b4.out_valid), 0);
    chk("midrst_data", 32'(b4.out_data), 0);
    q4.delete();
    #2;
    reset = 1'b1;
    tick();
    chk("postrst_valid", 32'(b4.out_valid), 0);
    b4.out_ready = 1'b1;
    #1;
    chk("c3_oor_ready", 32'(b3.in_ready), 0);
    chk("c3_oor_valid", 32'(b3.out_valid), 0);
    b3.mode = 1'b1; b3.in_valid = 3'b000;
    tick();
    b3.in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      q3.push_back({2'(k % 3), 4'(k % 3 + 1)});
      tick();
      out_is("c3_rr", 1);
    end
    chk("sb_drained", 32'(q4.size() + q3.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
